// File: rtl/fifo_pkg.sv
// Shared helpers for the n-word first-word-fall-through FIFO: width math,
// explicit pointer wrap and parameter sanity checks.
package fifo_pkg;

   function automatic int lvl_w(int depth);
      return $clog2(depth + 1);
   endfunction

   // Array holds depth-1 entries; keep at least one pointer bit for depth == 2.
   function automatic int ptr_w(int depth);
      return (depth > 2) ? $clog2(depth - 1) : 1;
   endfunction

   function automatic int ptr_wrap(int ptr, int depth);
      return (ptr >= depth - 2) ? 0 : ptr + 1;
   endfunction

   function automatic bit params_ok(int bits, int depth, int af, int ae);
      return (bits >= 1) && (depth >= 2) && (af >= 1) && (af <= depth) &&
             (ae >= 0) && (ae <= depth - 1);
   endfunction

endpackage

// File: rtl/fifo_regarray.sv
// Simple dual-port register array: one synchronous write port, one
// asynchronous read port, contents are not reset.
module fifo_regarray #(
   parameter int bits    = 8,
   parameter int ENTRIES = 3,
   parameter int PW      = 2
) (
   input  logic            clk,
   input  logic            we,
   input  logic [PW-1:0]   waddr,
   input  logic [bits-1:0] wdata,
   input  logic [PW-1:0]   raddr,
   output logic [bits-1:0] rdata
);

   logic [bits-1:0] mem [ENTRIES];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_nword_fwft.sv
// DEPTH-word FWFT FIFO: registered head word in front of a circular array,
// with occupancy, almost-full/empty flags and sticky error flags.
module fifo_nword_fwft
   import fifo_pkg::*;
#(
   parameter int bits     = 8,
   parameter int DEPTH    = 4,
   parameter int AF_LEVEL = DEPTH - 1,
   parameter int AE_LEVEL = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       shift_in,
   input  logic                       shift_out,
   input  logic [bits-1:0]            data_in,
   input  logic                       clear_errors,
   output logic [bits-1:0]            data_out,
   output logic                       fifo_not_empty,
   output logic                       fifo_full,
   output logic [$clog2(DEPTH+1)-1:0] level,
   output logic                       almost_full,
   output logic                       almost_empty,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int LW = lvl_w(DEPTH);
   localparam int PW = ptr_w(DEPTH);
   localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
   localparam logic [LW-1:0] AF_L    = LW'(AF_LEVEL);
   localparam logic [LW-1:0] AE_L    = LW'(AE_LEVEL);

`ifndef SYNTHESIS
   if (!params_ok(bits, DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_param_check
      $error("fifo_nword_fwft: parameter out of range");
   end
`endif

   logic [bits-1:0] data_q, data_d;
   logic [LW-1:0]   level_q, level_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic            not_empty_q, not_empty_d;
   logic            af_q, af_d, ae_q, ae_d;
   logic            ovf_q, ovf_d, udf_q, udf_d;
   logic            wr_ok, rd_ok, fall_through, arr_pop, arr_we;
   logic [bits-1:0] arr_rdata;

   fifo_regarray #(.bits(bits), .ENTRIES(DEPTH - 1), .PW(PW)) u_array (
      .clk   (clk),
      .we    (arr_we),
      .waddr (wr_ptr_q),
      .wdata (data_in),
      .raddr (rd_ptr_q),
      .rdata (arr_rdata)
   );

   // Only combinational output: a read in the same cycle frees a slot.
   assign fifo_full = (level_q == DEPTH_L) && !shift_out;

   always_comb begin
      wr_ok        = shift_in && !fifo_full;
      rd_ok        = shift_out && not_empty_q;
      fall_through = 1'b0;
      arr_pop      = 1'b0;
      data_d       = data_q;
      // Head register reloads when consumed or empty; array has words once level >= 2.
      if (rd_ok || !not_empty_q) begin
         if (level_q >= LW'(2)) begin
            data_d  = arr_rdata;
            arr_pop = 1'b1;
         end else if (wr_ok) begin
            data_d       = data_in;
            fall_through = 1'b1;
         end else begin
            data_d = '0;
         end
      end
      arr_we      = wr_ok && !fall_through;
      wr_ptr_d    = arr_we  ? PW'(ptr_wrap(int'(wr_ptr_q), DEPTH)) : wr_ptr_q;
      rd_ptr_d    = arr_pop ? PW'(ptr_wrap(int'(rd_ptr_q), DEPTH)) : rd_ptr_q;
      level_d     = level_q + LW'(wr_ok) - LW'(rd_ok);
      not_empty_d = (level_d != '0);
      af_d        = (level_d >= AF_L);
      ae_d        = (level_d <= AE_L);
      ovf_d       = (ovf_q && !clear_errors) || (shift_in && fifo_full);
      udf_d       = (udf_q && !clear_errors) || (shift_out && !not_empty_q);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         data_q      <= '0;
         level_q     <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         not_empty_q <= 1'b0;
         af_q        <= ('0 >= AF_L);
         ae_q        <= 1'b1;
         ovf_q       <= 1'b0;
         udf_q       <= 1'b0;
      end else begin
         data_q      <= data_d;
         level_q     <= level_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         not_empty_q <= not_empty_d;
         af_q        <= af_d;
         ae_q        <= ae_d;
         ovf_q       <= ovf_d;
         udf_q       <= udf_d;
      end
   end

   assign data_out       = data_q;
   assign level          = level_q;
   assign fifo_not_empty = not_empty_q;
   assign almost_full    = af_q;
   assign almost_empty   = ae_q;
   assign overflow       = ovf_q;
   assign underflow      = udf_q;

endmodule

// File: tb/tb_fifo_nword_fwft.sv
// Bench for fifo_nword_fwft: DEPTH=4 and DEPTH=5 instances share stimulus;
// words are pushed to an expected queue when written and checked when read.
module tb_fifo_nword_fwft;

   logic       clk = 1'b0;
   logic       reset, shift_in, shift_out, clear_errors;
   logic [7:0] data_in;

   logic [7:0] d4_dout, d5_dout;
   logic       d4_ne, d4_full, d4_af, d4_ae, d4_ovf, d4_udf;
   logic       d5_ne, d5_full, d5_af, d5_ae, d5_ovf, d5_udf;
   logic [2:0] d4_level, d5_level;

   logic [7:0] exp_q[$];
   int         n_vec = 0;
   int         n_err = 0;

   always #5 clk = ~clk;

   fifo_nword_fwft #(.bits(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1)) u_dut4 (
      .clk(clk), .reset(reset), .shift_in(shift_in), .shift_out(shift_out),
      .data_in(data_in), .clear_errors(clear_errors), .data_out(d4_dout),
      .fifo_not_empty(d4_ne), .fifo_full(d4_full), .level(d4_level),
      .almost_full(d4_af), .almost_empty(d4_ae), .overflow(d4_ovf), .underflow(d4_udf)
   );

   fifo_nword_fwft #(.bits(8), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1)) u_dut5 (
      .clk(clk), .reset(reset), .shift_in(shift_in), .shift_out(shift_out),
      .data_in(data_in), .clear_errors(clear_errors), .data_out(d5_dout),
      .fifo_not_empty(d5_ne), .fifo_full(d5_full), .level(d5_level),
      .almost_full(d5_af), .almost_empty(d5_ae), .overflow(d5_ovf), .underflow(d5_udf)
   );

   task automatic set_in(input logic si, input logic so, input logic [7:0] din, input logic clr);
      shift_in     = si;
      shift_out    = so;
      data_in      = din;
      clear_errors = clr;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      set_in(1'b0, 1'b0, 8'h00, 1'b0);
      tick();
      tick();
      reset = 1'b0;
      exp_q.delete();
   endtask

   task automatic test_reset();
      do_reset();
      n_vec++; if (d4_dout !== 8'h00) begin n_err++; $display("FAIL reset_dout got %h exp 00", d4_dout); end
      n_vec++; if (d4_ne !== 1'b0) begin n_err++; $display("FAIL reset_ne got %b exp 0", d4_ne); end
      n_vec++; if (d4_level !== 3'd0) begin n_err++; $display("FAIL reset_level got %0d exp 0", d4_level); end
      n_vec++; if ({d4_af, d4_ae} !== 2'b01) begin n_err++; $display("FAIL reset_af_ae got %b exp 01", {d4_af, d4_ae}); end
      n_vec++; if ({d4_ovf, d4_udf} !== 2'b00) begin n_err++; $display("FAIL reset_errs got %b exp 00", {d4_ovf, d4_udf}); end
   endtask

   task automatic test_fill();
      logic [7:0] words [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      for (int i = 0; i < 4; i++) begin
         set_in(1'b1, 1'b0, words[i], 1'b0);
         exp_q.push_back(words[i]);
         tick();
         n_vec++; if (d4_level !== 3'(i + 1)) begin n_err++; $display("FAIL fill_level[%0d] got %0d exp %0d", i, d4_level, i + 1); end
         n_vec++; if (d4_dout !== 8'h11) begin n_err++; $display("FAIL fill_dout[%0d] got %h exp 11", i, d4_dout); end
         n_vec++; if (d4_af !== (i + 1 >= 3)) begin n_err++; $display("FAIL fill_af[%0d] got %b exp %b", i, d4_af, (i + 1 >= 3)); end
         n_vec++; if (d4_ae !== (i + 1 <= 1)) begin n_err++; $display("FAIL fill_ae[%0d] got %b exp %b", i, d4_ae, (i + 1 <= 1)); end
      end
      set_in(1'b0, 1'b0, 8'h00, 1'b0);
      #1;
      n_vec++; if (d4_full !== 1'b1) begin n_err++; $display("FAIL fill_full got %b exp 1", d4_full); end
   endtask

   task automatic drain_d4(input string tag);
      for (int i = 0; i < 4; i++) begin
         set_in(1'b0, 1'b1, 8'h00, 1'b0);
         #1;
         n_vec++;
         if (exp_q.size() == 0) begin n_err++; $display("FAIL %s_scoreboard_empty got %h exp none", tag, d4_dout); end
         else begin
            if (d4_dout !== exp_q[0]) begin n_err++; $display("FAIL %s_data[%0d] got %h exp %h", tag, i, d4_dout, exp_q[0]); end
            void'(exp_q.pop_front());
         end
         tick();
      end
      set_in(1'b0, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic test_overflow();
      set_in(1'b1, 1'b0, 8'h55, 1'b0);
      #1;
      n_vec++; if (d4_full !== 1'b1) begin n_err++; $display("FAIL ovf_full got %b exp 1", d4_full); end
      tick();
      set_in(1'b0, 1'b0, 8'h00, 1'b0);
      n_vec++; if (d4_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %b exp 1", d4_ovf); end
      n_vec++; if (d4_level !== 3'd4) begin n_err++; $display("FAIL ovf_level got %0d exp 4", d4_level); end
      drain_d4("ovf_drain");
      n_vec++; if ({d4_level, d4_ne, d4_dout} !== {3'd0, 1'b0, 8'h00}) begin
         n_err++; $display("FAIL ovf_empty got lvl=%0d ne=%b d=%h exp 0/0/00", d4_level, d4_ne, d4_dout);
      end
   endtask

   task automatic test_full_in_out();
      for (int i = 0; i < 4; i++) begin
         set_in(1'b1, 1'b0, 8'(8'h11 * (i + 1)), 1'b0);
         exp_q.push_back(8'(8'h11 * (i + 1)));
         tick();
      end
      set_in(1'b1, 1'b1, 8'h66, 1'b0);
      #1;
      n_vec++; if (d4_full !== 1'b0) begin n_err++; $display("FAIL fio_full got %b exp 0", d4_full); end
      n_vec++; if (d4_dout !== exp_q[0]) begin n_err++; $display("FAIL fio_head got %h exp %h", d4_dout, exp_q[0]); end
      void'(exp_q.pop_front());
      exp_q.push_back(8'h66);
      tick();
      set_in(1'b0, 1'b0, 8'h00, 1'b0);
      n_vec++; if (d4_level !== 3'd4) begin n_err++; $display("FAIL fio_level got %0d exp 4", d4_level); end
      drain_d4("fio_drain");
      n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL fio_leftover got %0d exp 0", exp_q.size()); end
   endtask

   task automatic test_errors();
      set_in(1'b0, 1'b0, 8'h00, 1'b1);
      tick();
      n_vec++; if (d4_ovf !== 1'b0) begin n_err++; $display("FAIL clr_ovf got %b exp 0", d4_ovf); end
      set_in(1'b0, 1'b1, 8'h00, 1'b0);
      tick();
      n_vec++; if (d4_udf !== 1'b1) begin n_err++; $display("FAIL udf_flag got %b exp 1", d4_udf); end
      n_vec++; if ({d4_dout, d4_level} !== {8'h00, 3'd0}) begin n_err++; $display("FAIL udf_state got d=%h lvl=%0d exp 00/0", d4_dout, d4_level); end
      set_in(1'b0, 1'b0, 8'h00, 1'b1);
      tick();
      n_vec++; if (d4_udf !== 1'b0) begin n_err++; $display("FAIL udf_clear got %b exp 0", d4_udf); end
      set_in(1'b0, 1'b1, 8'h00, 1'b1);
      tick();
      n_vec++; if (d4_udf !== 1'b1) begin n_err++; $display("FAIL udf_clr_collide got %b exp 1", d4_udf); end
      set_in(1'b0, 1'b0, 8'h00, 1'b1);
      tick();
      set_in(1'b0, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic stream_d5(input int n, input logic [2:0] lvl, input logic [7:0] base);
      for (int i = 0; i < n; i++) begin
         set_in(1'b1, 1'b1, 8'(base + 8'(i)), 1'b0);
         #1;
         n_vec++;
         if (d5_dout !== exp_q[0]) begin n_err++; $display("FAIL stream_data[%0d] got %h exp %h", i, d5_dout, exp_q[0]); end
         void'(exp_q.pop_front());
         exp_q.push_back(8'(base + 8'(i)));
         tick();
         n_vec++; if (d5_level !== lvl) begin n_err++; $display("FAIL stream_level[%0d] got %0d exp %0d", i, d5_level, lvl); end
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      set_in(1'b1, 1'b0, 8'hA0, 1'b0);
      exp_q.push_back(8'hA0);
      tick();
      stream_d5(20, 3'd1, 8'hA1);
      for (int i = 0; i < 2; i++) begin
         set_in(1'b1, 1'b0, 8'(8'hC0 + 8'(i)), 1'b0);
         exp_q.push_back(8'(8'hC0 + 8'(i)));
         tick();
      end
      stream_d5(13, 3'd3, 8'hD0);
      for (int i = 0; i < 3; i++) begin
         set_in(1'b0, 1'b1, 8'h00, 1'b0);
         #1;
         n_vec++;
         if (d5_dout !== exp_q[0]) begin n_err++; $display("FAIL b2b_drain[%0d] got %h exp %h", i, d5_dout, exp_q[0]); end
         void'(exp_q.pop_front());
         tick();
      end
      set_in(1'b0, 1'b0, 8'h00, 1'b0);
      n_vec++; if ({d5_ne, d5_level} !== {1'b0, 3'd0}) begin n_err++; $display("FAIL b2b_empty got ne=%b lvl=%0d exp 0/0", d5_ne, d5_level); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         set_in(1'b1, 1'b0, 8'(8'h30 + 8'(i)), 1'b0);
         tick();
      end
      reset = 1'b1;
      set_in(1'b1, 1'b0, 8'h99, 1'b0);
      tick();
      reset = 1'b0;
      set_in(1'b0, 1'b0, 8'h00, 1'b0);
      n_vec++; if ({d4_level, d4_ne, d4_dout} !== {3'd0, 1'b0, 8'h00}) begin
         n_err++; $display("FAIL rst_mid got lvl=%0d ne=%b d=%h exp 0/0/00", d4_level, d4_ne, d4_dout);
      end
      set_in(1'b1, 1'b0, 8'h5A, 1'b0);
      tick();
      set_in(1'b0, 1'b0, 8'h00, 1'b0);
      n_vec++; if ({d4_level, d4_ne, d4_dout} !== {3'd1, 1'b1, 8'h5A}) begin
         n_err++; $display("FAIL rst_mid_write got lvl=%0d ne=%b d=%h exp 1/1/5a", d4_level, d4_ne, d4_dout);
      end
   endtask

   initial begin
      reset = 1'b1;
      set_in(1'b0, 1'b0, 8'h00, 1'b0);
      test_reset();
      test_fill();
      test_overflow();
      test_full_in_out();
      test_errors();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
